hmc_ctrl_regfile: RTL and testbench

Register-file slave on the controller side of the rf bus: decodes the 4-bit `rf_address` and 64-bit read/write requests issued by the register-file agent and replies with `rf_access_complete`/`rf_invalid_address`. It holds one RW control register, mirrors two status vectors, and maintains five saturating event counters fed by pulses from the TX/RX datapath. It sits directly downstream of the rf bus master and drives `control_out` into the controller core.

---
 rtl/hmc_rf_pkg.sv | 22 ++
 rtl/rf_event_counter.sv | 42 ++++
 rtl/hmc_ctrl_regfile.sv | 123 ++++++++++++
 tb/tb_hmc_ctrl_regfile.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/hmc_rf_pkg.sv
// Shared constants for the HMC controller register file: address map,
// access FSM states and the rf bus data width.
package hmc_rf_pkg;

    localparam int unsigned RF_DATA_W = 64;

    localparam logic [3:0] ADDR_STATUS_GENERAL = 4'h0;
    localparam logic [3:0] ADDR_STATUS_INIT    = 4'h1;
    localparam logic [3:0] ADDR_CONTROL        = 4'h2;
    localparam logic [3:0] ADDR_SENT_P         = 4'h3;
    localparam logic [3:0] ADDR_SENT_NP        = 4'h4;
    localparam logic [3:0] ADDR_SENT_R         = 4'h5;
    localparam logic [3:0] ADDR_POISONED       = 4'h6;
    localparam logic [3:0] ADDR_RCVD_RSP       = 4'h7;
    localparam logic [3:0] ADDR_COUNTER_RESET  = 4'h8;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rf_event_counter.sv
// Saturating event counter: +1 per inc pulse, sticks at all-ones,
// a clear in the same cycle as an increment wins.
module rf_event_counter #(
    parameter int CNT_W = 48
) (
    input  logic             clk,
    input  logic             res,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Next count: clear, saturating increment, or hold
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (res) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hmc_ctrl_regfile.sv
// Controller-side rf bus slave: CONTROL register, status mirrors and five
// saturating event counters behind a two-state request/acknowledge FSM.
module hmc_ctrl_regfile
    import hmc_rf_pkg::*;
#(
    parameter int          CNT_W       = 48,
    parameter logic [63:0] CONTROL_RST = 64'h0
) (
    input  logic        clk,
    input  logic        res,
    input  logic [3:0]  rf_address,
    input  logic [63:0] rf_write_data,
    input  logic        rf_read_enable,
    input  logic        rf_write_enable,
    output logic [63:0] rf_read_data,
    output logic        rf_access_complete,
    output logic        rf_invalid_address,
    input  logic [63:0] status_general,
    input  logic [63:0] status_init,
    input  logic        sent_p_inc,
    input  logic        sent_np_inc,
    input  logic        sent_r_inc,
    input  logic        poisoned_inc,
    input  logic        rcvd_rsp_inc,
    output logic [63:0] control_out
);

    rf_state_t state_d, state_q;
    logic [RF_DATA_W-1:0] rdata_d, rdata_q;
    logic [RF_DATA_W-1:0] control_d, control_q;
    logic complete_d, complete_q;
    logic invalid_d, invalid_q;
    logic cnt_clr_s;

    logic [4:0]       cnt_inc_s;
    logic [CNT_W-1:0] cnt_s [5];

    // Counter order follows the address map, SENT_P (0x3) first
    assign cnt_inc_s = {rcvd_rsp_inc, poisoned_inc, sent_r_inc, sent_np_inc, sent_p_inc};

    for (genvar i = 0; i < 5; i++) begin : g_cnt
        rf_event_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .res   (res),
            .inc   (cnt_inc_s[i]),
            .clr   (cnt_clr_s),
            .count (cnt_s[i])
        );
    end

    // Access decode: one request accepted in IDLE, answered in ACK
    always_comb begin
        state_d    = state_q;
        complete_d = 1'b0;
        invalid_d  = 1'b0;
        rdata_d    = '0;
        control_d  = control_q;
        cnt_clr_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rf_read_enable || rf_write_enable) begin
                    state_d    = ACK;
                    complete_d = 1'b1;
                    if (rf_read_enable && rf_write_enable) begin
                        invalid_d = 1'b1;
                    end else if (rf_read_enable) begin
                        case (rf_address)
                            ADDR_STATUS_GENERAL: rdata_d = status_general;
                            ADDR_STATUS_INIT:    rdata_d = status_init;
                            ADDR_CONTROL:        rdata_d = control_q;
                            ADDR_SENT_P:         rdata_d = 64'(cnt_s[0]);
                            ADDR_SENT_NP:        rdata_d = 64'(cnt_s[1]);
                            ADDR_SENT_R:         rdata_d = 64'(cnt_s[2]);
                            ADDR_POISONED:       rdata_d = 64'(cnt_s[3]);
                            ADDR_RCVD_RSP:       rdata_d = 64'(cnt_s[4]);
                            ADDR_COUNTER_RESET:  rdata_d = 64'h0;
                            default:             invalid_d = 1'b1;
                        endcase
                    end else begin
                        case (rf_address)
                            ADDR_CONTROL:       control_d = rf_write_data;
                            ADDR_COUNTER_RESET: cnt_clr_s = 1'b1;
                            default:            invalid_d = 1'b1;
                        endcase
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered bus outputs
    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= IDLE;
            complete_q <= 1'b0;
            invalid_q  <= 1'b0;
            rdata_q    <= 64'h0;
            control_q  <= CONTROL_RST;
        end else begin
            state_q    <= state_d;
            complete_q <= complete_d;
            invalid_q  <= invalid_d;
            rdata_q    <= rdata_d;
            control_q  <= control_d;
        end
    end

    assign rf_access_complete = complete_q;
    assign rf_invalid_address = invalid_q;
    assign rf_read_data       = rdata_q;
    assign control_out        = control_q;

endmodule

// File: tb/tb_hmc_ctrl_regfile.sv
// Directed bench for hmc_ctrl_regfile: a vector table of single accesses
// plus hand-written sequences for counters, held enables and reset.
module tb_hmc_ctrl_regfile;

    localparam int          CNT_W    = 4;
    localparam logic [63:0] CTRL_RST = 64'h0123_0000_0000_00A5;
    localparam logic [63:0] SG_VAL   = 64'hA5A5_0000_FFFF_1234;
    localparam logic [63:0] SI_VAL   = 64'h0000_0001_8000_0003;
    localparam logic [63:0] DB_VAL   = 64'hDEAD_BEEF_0123_4567;

    logic        clk;
    logic        res;
    logic [3:0]  rf_address;
    logic [63:0] rf_write_data;
    logic        rf_read_enable;
    logic        rf_write_enable;
    logic [63:0] rf_read_data;
    logic        rf_access_complete;
    logic        rf_invalid_address;
    logic [63:0] status_general;
    logic [63:0] status_init;
    logic [4:0]  evt;
    logic [63:0] control_out;

    int n_checks;
    int n_fail;

    typedef struct {
        logic        re;
        logic        we;
        logic [3:0]  addr;
        logic [63:0] wdata;
        logic        exp_inv;
        logic [63:0] exp_rdata;
        logic [63:0] exp_ctrl;
    } vec_t;

    vec_t vecs [17];

    hmc_ctrl_regfile #(
        .CNT_W       (CNT_W),
        .CONTROL_RST (CTRL_RST)
    ) dut (
        .clk                (clk),
        .res                (res),
        .rf_address         (rf_address),
        .rf_write_data      (rf_write_data),
        .rf_read_enable     (rf_read_enable),
        .rf_write_enable    (rf_write_enable),
        .rf_read_data       (rf_read_data),
        .rf_access_complete (rf_access_complete),
        .rf_invalid_address (rf_invalid_address),
        .status_general     (status_general),
        .status_init        (status_init),
        .sent_p_inc         (evt[0]),
        .sent_np_inc        (evt[1]),
        .sent_r_inc         (evt[2]),
        .poisoned_inc       (evt[3]),
        .rcvd_rsp_inc       (evt[4]),
        .control_out        (control_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge with the DUT idle; returns likewise.
    task automatic access(input string name, input logic re, input logic we,
                          input logic [3:0] addr, input logic [63:0] wdata,
                          input logic exp_inv, input logic [63:0] exp_rdata,
                          input logic [63:0] exp_ctrl);
        rf_read_enable  = re;
        rf_write_enable = we;
        rf_address      = addr;
        rf_write_data   = wdata;
        @(posedge clk); #1;
        check({name, " complete"}, 64'(rf_access_complete), 64'h1);
        check({name, " invalid"},  64'(rf_invalid_address), 64'(exp_inv));
        check({name, " rdata"},    rf_read_data, exp_rdata);
        check({name, " control"},  control_out, exp_ctrl);
        rf_read_enable  = 1'b0;
        rf_write_enable = 1'b0;
        @(posedge clk); #1;
        check({name, " idle complete"}, 64'(rf_access_complete), 64'h0);
        check({name, " idle rdata"},    rf_read_data, 64'h0);
        check({name, " idle invalid"},  64'(rf_invalid_address), 64'h0);
    endtask

    task automatic pulse(input int which, input int n);
        for (int k = 0; k < n; k++) begin
            evt[which] = 1'b1;
            @(posedge clk); #1;
            evt[which] = 1'b0;
        end
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        res             = 1'b1;
        rf_address      = 4'h0;
        rf_write_data   = 64'h0;
        rf_read_enable  = 1'b0;
        rf_write_enable = 1'b0;
        status_general  = SG_VAL;
        status_init     = SI_VAL;
        evt             = 5'b0;

        //                re    we    addr   wdata            inv   rdata     ctrl
        vecs[0]  = '{1'b1, 1'b0, 4'h2, 64'h0,           1'b0, CTRL_RST, CTRL_RST};
        vecs[1]  = '{1'b1, 1'b0, 4'h0, 64'h0,           1'b0, SG_VAL,   CTRL_RST};
        vecs[2]  = '{1'b1, 1'b0, 4'h1, 64'h0,           1'b0, SI_VAL,   CTRL_RST};
        vecs[3]  = '{1'b1, 1'b0, 4'h3, 64'h0,           1'b0, 64'h0,    CTRL_RST};
        vecs[4]  = '{1'b1, 1'b0, 4'h4, 64'h0,           1'b0, 64'h0,    CTRL_RST};
        vecs[5]  = '{1'b1, 1'b0, 4'h5, 64'h0,           1'b0, 64'h0,    CTRL_RST};
        vecs[6]  = '{1'b1, 1'b0, 4'h6, 64'h0,           1'b0, 64'h0,    CTRL_RST};
        vecs[7]  = '{1'b1, 1'b0, 4'h7, 64'h0,           1'b0, 64'h0,    CTRL_RST};
        vecs[8]  = '{1'b1, 1'b0, 4'h8, 64'h0,           1'b0, 64'h0,    CTRL_RST};
        vecs[9]  = '{1'b0, 1'b1, 4'h2, DB_VAL,          1'b0, 64'h0,    DB_VAL};
        vecs[10] = '{1'b1, 1'b0, 4'h2, 64'h0,           1'b0, DB_VAL,   DB_VAL};
        vecs[11] = '{1'b1, 1'b0, 4'hA, 64'h0,           1'b1, 64'h0,    DB_VAL};
        vecs[12] = '{1'b0, 1'b1, 4'h0, 64'h5555,        1'b1, 64'h0,    DB_VAL};
        vecs[13] = '{1'b1, 1'b1, 4'h2, 64'h1111,        1'b1, 64'h0,    DB_VAL};
        vecs[14] = '{1'b0, 1'b1, 4'h5, 64'h7,           1'b1, 64'h0,    DB_VAL};
        vecs[15] = '{1'b0, 1'b1, 4'hF, 64'h9,           1'b1, 64'h0,    DB_VAL};
        vecs[16] = '{1'b1, 1'b0, 4'h2, 64'h0,           1'b0, DB_VAL,   DB_VAL};

        repeat (2) @(posedge clk);
        #1;
        res = 1'b0;
        check("reset complete", 64'(rf_access_complete), 64'h0);
        check("reset invalid",  64'(rf_invalid_address), 64'h0);
        check("reset rdata",    rf_read_data, 64'h0);
        check("reset control",  control_out, CTRL_RST);

        for (int i = 0; i < 17; i++) begin
            access($sformatf("vec%0d", i), vecs[i].re, vecs[i].we, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_inv, vecs[i].exp_rdata, vecs[i].exp_ctrl);
        end

        // Distinct counts per counter catch swapped wiring
        pulse(0, 5);
        pulse(1, 2);
        pulse(2, 3);
        pulse(4, 1);
        access("sent_p 5",   1'b1, 1'b0, 4'h3, 64'h0, 1'b0, 64'd5, DB_VAL);
        access("sent_np 2",  1'b1, 1'b0, 4'h4, 64'h0, 1'b0, 64'd2, DB_VAL);
        access("sent_r 3",   1'b1, 1'b0, 4'h5, 64'h0, 1'b0, 64'd3, DB_VAL);
        access("rcvd_rsp 1", 1'b1, 1'b0, 4'h7, 64'h0, 1'b0, 64'd1, DB_VAL);
        access("clear",      1'b0, 1'b1, 4'h8, 64'hFFFF, 1'b0, 64'h0, DB_VAL);
        access("sent_p clr", 1'b1, 1'b0, 4'h3, 64'h0, 1'b0, 64'd0, DB_VAL);
        access("sent_r clr", 1'b1, 1'b0, 4'h5, 64'h0, 1'b0, 64'd0, DB_VAL);

        // Clear coincident with an increment: clear wins
        pulse(0, 3);
        evt[0]          = 1'b1;
        rf_write_enable = 1'b1;
        rf_address      = 4'h8;
        @(posedge clk); #1;
        evt[0]          = 1'b0;
        rf_write_enable = 1'b0;
        check("coincident complete", 64'(rf_access_complete), 64'h1);
        @(posedge clk); #1;
        access("coincident read", 1'b1, 1'b0, 4'h3, 64'h0, 1'b0, 64'd0, DB_VAL);

        // Saturation at 2^CNT_W-1
        pulse(3, 20);
        access("poisoned sat", 1'b1, 1'b0, 4'h6, 64'h0, 1'b0, 64'd15, DB_VAL);

        // Enable held through ACK: one pulse only
        rf_read_enable = 1'b1;
        rf_address     = 4'h1;
        @(posedge clk); #1;
        check("held ack complete", 64'(rf_access_complete), 64'h1);
        check("held ack rdata",    rf_read_data, SI_VAL);
        @(posedge clk); #1;
        check("held 2nd complete", 64'(rf_access_complete), 64'h0);
        rf_read_enable = 1'b0;
        @(posedge clk); #1;
        check("held 3rd complete", 64'(rf_access_complete), 64'h0);

        // Reset during ACK drops the response
        rf_read_enable = 1'b1;
        rf_address     = 4'hB;
        @(posedge clk); #1;
        rf_read_enable = 1'b0;
        check("ack-rst pre complete", 64'(rf_access_complete), 64'h1);
        res = 1'b1;
        @(posedge clk); #1;
        res = 1'b0;
        check("ack-rst complete", 64'(rf_access_complete), 64'h0);
        check("ack-rst invalid",  64'(rf_invalid_address), 64'h0);
        check("ack-rst control",  control_out, CTRL_RST);

        // Reset in the request cycle: write not applied, counters cleared
        rf_write_enable = 1'b1;
        rf_address      = 4'h2;
        rf_write_data   = 64'h0BAD_0BAD_0BAD_0BAD;
        res             = 1'b1;
        @(posedge clk); #1;
        res             = 1'b0;
        rf_write_enable = 1'b0;
        check("req-rst complete", 64'(rf_access_complete), 64'h0);
        check("req-rst control",  control_out, CTRL_RST);
        access("req-rst poisoned", 1'b1, 1'b0, 4'h6, 64'h0, 1'b0, 64'd0, CTRL_RST);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
